exec_sequencer: RTL
===================

Name: exec_sequencer

Overview:
- Execute/write-back sequencer sitting directly downstream of the dual-read-port SRAM register/data memory.
- Accepts one decoded instruction at a time and drives the SRAM read addresses and chip select.
- Captures the two read words one cycle later, runs an ALU operation on them, then issues a single-cycle write-back of the result to the SRAM.

Parameters:
- ADDR, 8, SRAM address width; each operand/destination field is ADDR bits.
- WIDTH, 32, data word width.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer idle, can accept.
- instr  in  4+3*ADDR  {opcode[3:0], dst, src1, src2}, MSB first.
- sram_cs  out  1  SRAM chip select / read strobe.
- sram_raddr1  out  ADDR  src1 address.
- sram_raddr2  out  ADDR  src2 address.
- sram_rdata1  in  WIDTH  word at raddr1, valid the cycle after sram_cs.
- sram_rdata2  in  WIDTH  word at raddr2, valid the cycle after sram_cs.
- sram_we  out  1  write strobe, one cycle.
- sram_waddr  out  ADDR  write address (dst).
- sram_wdata  out  WIDTH  write data (result).
- done  out  1  one-cycle pulse when the instruction retires.
- flag_z  out  1  result == 0, registered at retire.
- flag_c  out  1  carry out (ADD) / borrow (SUB), else 0.
- flag_v  out  1  signed overflow (ADD/SUB), else 0.
- err  out  1  one-cycle pulse with done for an illegal opcode.

Behaviour:
- Reset values (async, rst_n low): state IDLE; instr_ready=1; all other outputs 0; operand, result and instruction registers 0.
- Reset mid-operation aborts the instruction immediately. No write is issued, and no done is produced for it.
- Handshake: the instruction is accepted on a rising edge with instr_valid & instr_ready. instr_ready is 1 only in IDLE.
- instr is latched at accept and is not sampled again until the next accept.
- States and transitions:
  - IDLE: on accept go to RD.
  - RD: sram_cs=1, sram_raddr1/2 = latched src1/src2; next state CAP.
  - CAP: op_a <= sram_rdata1, op_b <= sram_rdata2; next state EX.
  - EX (single-cycle op): result and flags registered; next state WB.
  - EX (MUL): runs a shift-add loop, one bit per cycle, WIDTH cycles, counter 0..WIDTH-1; goes to WB after the last bit.
  - WB: sram_we=1, sram_waddr=dst, sram_wdata=result, done=1; next state IDLE.
- Latency, with accept edge = T0:
  - Single-cycle ops: done is high in the cycle after edge T3, i.e. 4 cycles after accept.
  - MUL: done is 4+WIDTH-1 cycles after accept.
  - Back-to-back throughput: one instruction per 5 cycles, because the accept edge in IDLE costs one cycle.
- sram_raddr1/2 and sram_waddr hold their values outside their strobes. sram_cs and sram_we are low in every state other than RD and WB respectively.
- Opcodes:
  - 0 NOP: full sequence runs, sram_we stays 0, done=1.
  - 1 ADD: WIDTH+1-bit sum; carry = bit WIDTH.
  - 2 SUB: a-b; flag_c = borrow (a<b unsigned).
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 SLL, 7 SRL, 8 SRA: shift op_a by op_b[SHW-1:0].
  - 9 MUL: low WIDTH bits of the unsigned product.
  - 10 SLT: signed a<b gives 1, else 0.
  - 11-15 illegal: sram_we stays 0, done=1, err=1; flags keep their previous values.
- Flags update only when a legal non-NOP instruction retires; otherwise they hold.
- flag_v for ADD: operand signs equal and result sign differs. For SUB: operand signs differ and result sign differs from a.
- src1 == src2 == dst is legal. The write lands after both reads, so there is no hazard inside the block.
- All arithmetic is modulo 2^WIDTH.

Decomposition:
- Shared package exec_pkg:
  - opcode localparams OP_NOP..OP_SLT;
  - state encoding S_IDLE, S_RD, S_CAP, S_EX, S_WB;
  - instruction field offset constants.
- One sub-module, exec_alu: combinational single-cycle ops plus flag generation.
- The MUL iteration stays in the sequencer, because it needs the state counter.

Test Plan:
- Reset: hold rst_n=0, then release. Required: instr_ready=1, sram_cs=sram_we=done=0.
- ADD, instr {1, dst=0x10, src1=0x01, src2=0x02}, mem[1]=0xFFFFFFFF, mem[2]=0x00000001. Required:
  - sram_cs high for exactly 1 cycle;
  - 4 cycles after accept: sram_we=1, waddr=0x10, wdata=0x00000000, flag_z=1, flag_c=1, flag_v=0.
- SUB with 0x80000000 - 0x00000001. Required: wdata=0x7FFFFFFF, flag_v=1, flag_c=0.
- MUL with 0x0000FFFF * 0x00010001. Required:
  - wdata=0xFFFFFFFF;
  - done exactly 4+31 cycles after accept;
  - instr_ready=0 throughout.
- Opcode 12 (illegal). Required: done=1, err=1, sram_we stays 0, flags unchanged from the prior ADD.
- Reset asserted during MUL EX, cycle 10. Required: outputs zero immediately, no sram_we pulse, instr_ready=1 after release, next ADD retires correctly.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants for the execute/write-back sequencer: opcodes, FSM state codes,
// instruction field positions and flag bundle.
package exec_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_SLT = 4'd10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    // Field positions in units of ADDR bits, counted from the LSB of instr.
    localparam int unsigned FLD_SRC2 = 0;
    localparam int unsigned FLD_SRC1 = 1;
    localparam int unsigned FLD_DST  = 2;
    localparam int unsigned FLD_OPC  = 3;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_SLT;
    endfunction

    function automatic logic op_writes(input logic [3:0] op);
        return op_is_legal(op) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational single-cycle ALU for the sequencer; produces result and z/c/v flags.
module exec_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                result  = sum[WIDTH-1:0];
                flags.c = sum[WIDTH];
                flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the unsigned borrow.
                result  = diff[WIDTH-1:0];
                flags.c = diff[WIDTH];
                flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLL: result = a << shamt;
            OP_SRL: result = a >> shamt;
            OP_SRA: result = $signed(a) >>> shamt;
            OP_SLT: result[0] = $signed(a) < $signed(b);
            default: result = '0;
        endcase
        flags.z = (result == '0);
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execute/write-back sequencer: reads two SRAM operands, runs the ALU (or an
// iterative MUL), then writes the result back in a single strobe.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4+3*ADDR-1:0] instr,
    output logic              sram_cs,
    output logic [ADDR-1:0]   sram_raddr1,
    output logic [ADDR-1:0]   sram_raddr2,
    input  logic [WIDTH-1:0]  sram_rdata1,
    input  logic [WIDTH-1:0]  sram_rdata2,
    output logic              sram_we,
    output logic [ADDR-1:0]   sram_waddr,
    output logic [WIDTH-1:0]  sram_wdata,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              err
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int ILEN = 4 + 3 * ADDR;

    logic [2:0]       state_q, state_d;
    logic [ILEN-1:0]  instr_q, instr_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    flags_t           flags_q, flags_d;

    logic [3:0]       opc;
    logic [WIDTH-1:0] alu_result;
    flags_t           alu_flags;
    logic [WIDTH-1:0] mul_term;
    logic [WIDTH-1:0] mul_next;

    assign opc = instr_q[FLD_OPC*ADDR +: 4];

    exec_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op    (opc),
        .a     (op_a_q),
        .b     (op_b_q),
        .result(alu_result),
        .flags (alu_flags)
    );

    // Shift-add multiply: one multiplier bit per EX cycle, result_q is the accumulator.
    assign mul_term = op_b_q[cnt_q] ? (op_a_q << cnt_q) : '0;
    assign mul_next = result_q + mul_term;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                op_a_d  = sram_rdata1;
                op_b_d  = sram_rdata2;
                cnt_d   = '0;
                if (opc == OP_MUL) begin
                    result_d = '0;
                end
                state_d = S_EX;
            end
            S_EX: begin
                if (opc == OP_MUL) begin
                    result_d = mul_next;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        flags_d.z = (mul_next == '0);
                        flags_d.c = 1'b0;
                        flags_d.v = 1'b0;
                        state_d   = S_WB;
                    end
                end else begin
                    if (op_writes(opc)) begin
                        result_d = alu_result;
                        flags_d  = alu_flags;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign sram_cs     = (state_q == S_RD);
    assign sram_raddr1 = instr_q[FLD_SRC1*ADDR +: ADDR];
    assign sram_raddr2 = instr_q[FLD_SRC2*ADDR +: ADDR];
    assign sram_waddr  = instr_q[FLD_DST*ADDR +: ADDR];
    assign sram_wdata  = result_q;
    assign sram_we     = (state_q == S_WB) && op_writes(opc);
    assign done        = (state_q == S_WB);
    assign err         = (state_q == S_WB) && !op_is_legal(opc);
    assign flag_z      = flags_q.z;
    assign flag_c      = flags_q.c;
    assign flag_v      = flags_q.v;

endmodule
